instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Sequences the combinational instruction ROM. Owns the program counter, drives the ROM address every cycle, and buffers fetched {pc, instruction} pairs in a small queue. Decode consumes the queue through a valid/ready handshake. Handles start, branch redirect with flush, and bounds/alignment faults, so the ROM's own assertions never fire.

Parameters:
MEM_SIZE, 1024, ROM size in bytes; power of two, >4.
QDEPTH, 4, fetch-queue entries; power of two, >=2.
RESET_PC, 16'h0000, PC loaded at reset; word-aligned.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; leaves IDLE.
redirect_valid  in  1  branch/jump redirect request.
redirect_addr  in  16  new PC for a redirect.
imem_addr  out  16  ROM byte address; always equals pc.
imem_instr  in  16  ROM read data; combinational from imem_addr.
out_valid  out  1  queue head is valid.
out_instr  out  16  instruction at queue head.
out_pc  out  16  PC of queue-head instruction.
out_ready  in  1  decode accepts head this cycle.
fault  out  1  fetch stopped on a bad PC.
fault_addr  out  16  offending PC, captured when fault rises.
busy  out  1  state==RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: pc=RESET_PC, so imem_addr=RESET_PC. Queue empty, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_addr=0, state=IDLE, busy=0.
- A PC is legal when pc[1:0]==0 and pc+3 < MEM_SIZE. Compute in 17 bits so there is no wrap.
- pop = out_valid & out_ready. push_ok = !full | pop.
- States: IDLE, RUN, FAULT.
- IDLE:
  - No pushes.
  - start -> RUN.
  - redirect in IDLE loads pc and stays IDLE. An illegal target goes to FAULT.
- RUN, per cycle, in priority order:
  1. redirect_valid:
     - Flush every queue entry. A pop in the same cycle still completes.
     - No push this cycle.
     - pc <= redirect_addr.
     - Illegal target -> FAULT, fault_addr <= redirect_addr.
  2. pc illegal -> FAULT, fault_addr <= pc, no push, pc holds.
  3. push_ok -> push {pc, imem_instr}, pc <= pc+4.
  4. Otherwise (queue full, no pop) -> pc and imem_addr hold.
- FAULT:
  - fault=1; no pushes.
  - Already-queued entries still drain to decode.
  - Redirect to a legal target clears fault, flushes the queue, loads pc, -> RUN.
  - Redirect to an illegal target stays in FAULT and updates fault_addr.
  - start is ignored.
- start is ignored in RUN.
- Latency: start sampled at edge N -> RUN. First push at edge N+1. out_valid=1 after N+1, out_pc=RESET_PC.
- Throughput: one instruction per cycle while out_ready=1.
- Redirect at edge R: out_valid=0 after R. First new instruction is valid after R+1.
- Queue:
  - Circular buffer with wrapping read/write pointers and a count of width clog2(QDEPTH)+1.
  - Push and pop in the same cycle when full are legal; count is unchanged.
  - out_instr/out_pc are registered queue contents, held stable while out_valid & !out_ready.
- Reset asserted mid-operation: immediate return to reset values and queue cleared. Deassertion is synchronous to clk at the user level.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef addr_t (16-bit) and instr_t (16-bit).
  - enum fetch_state_e {IDLE, RUN, FAULT}.
  - constant PC_STRIDE=4.
  - function pc_legal(addr, mem_size).
- Sub-module fetch_queue: parameterized QDEPTH FIFO of {addr_t, instr_t}.
  - Ports: push, pop, flush, head, full, empty.
  - Instantiated once. The top holds the FSM and PC logic.

Test Plan:
- Basic stream: reset, start, out_ready=1 with instr ROM loaded from a small binary file. -> out_pc sequence 0,4,8,12… one per cycle, out_instr matching the file, first out_valid two edges after start.
- Backpressure: out_ready=0 for 10 cycles. -> exactly 4 entries queued, imem_addr frozen at 16, head held at pc 0. Release -> pc 0,4,8,12,16 with no gaps or duplicates.
- Redirect with full queue plus simultaneous pop: redirect_addr=0x40. -> queue flushed, out_valid=0 for one cycle, then out_pc=0x40,0x44.
- End of memory: redirect to 0x3F8, run. -> pushes 0x3F8 and 0x3FC, then fault=1, fault_addr=0x400, both entries still drain.
- Misaligned redirect to 0x0042. -> FAULT, fault_addr=0x0042, no push. A following redirect to 0x10 -> fault=0, out_pc=0x10.
- Async reset mid-RUN with a non-empty queue. -> out_valid, busy and fault drop immediately, imem_addr=0. After start, fetch resumes at 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types, constants and the PC legality rule for the instruction fetch block.
package fetch_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [15:0] instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

  localparam addr_t PC_STRIDE = 16'd4;

  // Last byte of the word is checked in 17 bits so addresses near 16'hFFFF cannot wrap.
  function automatic logic pc_legal(addr_t addr, int unsigned mem_size);
    logic [16:0] last_byte;
    last_byte = {1'b0, addr} + 17'd3;
    return (addr[1:0] == 2'b00) && ({15'b0, last_byte} < mem_size);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, instr} pairs; head is read straight from registered storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_data_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem_q [QDEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;

  // Storage is cleared on reset so the head reads zero before the first push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + 1'b1;
      end else if (!push_i && pop_i) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(QDEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the ROM and feeds decode through a small queue.
//   state | meaning
//   IDLE  | waiting for start; redirects only load the PC
//   RUN   | fetching one word per cycle while the queue has room
//   FAULT | stopped on an illegal PC; queued entries still drain
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024,
  parameter int          QDEPTH   = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  input  logic        out_ready,
  output logic        fault,
  output logic [15:0] fault_addr,
  output logic        busy
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  addr_t        fault_addr_q, fault_addr_d;

  logic         push, flush, pop, push_ok;
  logic         full, empty;
  logic         pc_ok, redir_ok;
  fetch_entry_t head, push_data;

  assign pop       = out_valid & out_ready;
  assign push_ok   = !full | pop;
  assign pc_ok     = pc_legal(pc_q, MEM_SIZE);
  assign redir_ok  = pc_legal(redirect_addr, MEM_SIZE);
  assign push_data = '{pc: pc_q, instr: imem_instr};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    push         = 1'b0;
    flush        = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_addr;
          if (!redir_ok) begin
            state_d      = FAULT;
            fault_addr_d = redirect_addr;
          end else if (start) begin
            state_d = RUN;
          end
        end else if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redirect_addr;
          if (!redir_ok) begin
            state_d      = FAULT;
            fault_addr_d = redirect_addr;
          end
        end else if (!pc_ok) begin
          state_d      = FAULT;
          fault_addr_d = pc_q;
        end else if (push_ok) begin
          push = 1'b1;
          pc_d = pc_q + PC_STRIDE;
        end
      end
      FAULT: begin
        // An illegal retarget keeps the queue so earlier fetches can still drain.
        if (redirect_valid) begin
          pc_d = redirect_addr;
          if (redir_ok) begin
            flush   = 1'b1;
            state_d = RUN;
          end else begin
            fault_addr_d = redirect_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (flush),
    .push_data_i (push_data),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign imem_addr  = pc_q;
  assign out_valid  = !empty;
  assign out_instr  = head.instr;
  assign out_pc     = head.pc;
  assign fault      = (state_q == FAULT);
  assign fault_addr = fault_addr_q;
  assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench: the expected fetch stream is the run of legal word addresses from each start/redirect target.
module tb_instr_fetch_ctrl;

  localparam int MEM_SIZE = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready;
  logic        fault;
  logic [15:0] fault_addr;
  logic        busy;

  logic [15:0] rom [512];
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  assign imem_instr = rom[imem_addr[9:1]];

  instr_fetch_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .fault          (fault),
    .fault_addr     (fault_addr),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input int a);
    return (a % 4 == 0) && (a + 3 < MEM_SIZE);
  endfunction

  // Expected deliveries after a (re)start at address a: every legal word from a upward.
  task automatic load_stream(input int a);
    exp_q.delete();
    if (legal(a)) begin
      for (int x = a; x + 3 < MEM_SIZE; x += 4) exp_q.push_back(16'(x));
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    load_stream(0);
    #1 start = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    @(posedge clk);
    load_stream(int'(a));
    #1 redirect_valid = 1'b0;
  endtask

  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_out_pc", out_pc, 0);
    exp_q.delete();
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL pop_unexpected: got pc %0h expected no delivery at %0t", out_pc, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_pc", out_pc, mon_e);
        check("pop_instr", out_instr, rom[mon_e[9:1]]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 16'($urandom);
    reset_n        = 1'b1;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 16'h0;
    out_ready      = 1'b0;

    #2 reset_n = 1'b0;
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_instr", out_instr, 0);
    check("reset_pc", out_pc, 0);
    check("reset_fault", fault, 0);
    check("reset_fault_addr", fault_addr, 0);
    check("reset_busy", busy, 0);
    check("reset_imem_addr", imem_addr, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(3);
    check("idle_busy", busy, 0);
    check("idle_no_push", out_valid, 0);

    // Basic stream
    out_ready = 1'b1;
    pulse_start();
    check("start_busy", busy, 1);
    check("start_latency_valid", out_valid, 0);
    cyc(1);
    check("first_valid", out_valid, 1);
    check("first_pc", out_pc, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("thru_valid", out_valid, 1);
    end

    // Backpressure from a fresh start
    mid_reset();
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_pc", out_pc, 0);
    end
    check("bp_imem_addr", imem_addr, 16'h10);
    check("bp_busy", busy, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check("bp_release_valid", out_valid, 1);
    end

    // Redirect with a full queue and a simultaneous pop
    out_ready = 1'b0;
    cyc(6);
    out_ready = 1'b1;
    redirect(16'h40);
    check("redir_flush_valid", out_valid, 0);
    cyc(1);
    check("redir_first_valid", out_valid, 1);
    check("redir_first_pc", out_pc, 16'h40);
    cyc(1);
    check("redir_second_pc", out_pc, 16'h44);

    // Run off the end of memory; entries fetched before the fault still drain
    out_ready = 1'b0;
    redirect(16'h3F8);
    cyc(5);
    check("eom_fault", fault, 1);
    check("eom_fault_addr", fault_addr, 16'h400);
    check("eom_busy", busy, 0);
    check("eom_head_valid", out_valid, 1);
    check("eom_head_pc", out_pc, 16'h3F8);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("fault_ignores_start", fault, 1);
    out_ready = 1'b1;
    cyc(4);
    check("eom_drained_valid", out_valid, 0);
    check("eom_drained_all", exp_q.size(), 0);

    // Recover, then misaligned redirect, then recover again
    redirect(16'h100);
    check("recover_fault", fault, 0);
    check("recover_busy", busy, 1);
    cyc(3);
    redirect(16'h42);
    check("misalign_fault", fault, 1);
    check("misalign_fault_addr", fault_addr, 16'h42);
    check("misalign_valid", out_valid, 0);
    cyc(3);
    check("misalign_no_push", out_valid, 0);
    redirect(16'h10);
    check("misalign_recover_fault", fault, 0);
    cyc(1);
    check("misalign_recover_valid", out_valid, 1);
    check("misalign_recover_pc", out_pc, 16'h10);

    // Async reset while running with a non-empty queue
    out_ready = 1'b0;
    cyc(3);
    mid_reset();
    check("post_reset_imem_addr", imem_addr, 0);
    out_ready = 1'b1;
    pulse_start();
    cyc(1);
    check("resume_valid", out_valid, 1);
    check("resume_pc", out_pc, 0);

    // Random backpressure, spurious starts and legal retargets
    for (int i = 0; i < 600; i++) begin
      out_ready = (($urandom % 4) != 0);
      start     = (($urandom % 50) == 0);
      if (($urandom % 30) == 0) begin
        redirect_valid = 1'b1;
        if (($urandom % 4) == 0) redirect_addr = 16'(MEM_SIZE - 4 * int'($urandom_range(1, 6)));
        else redirect_addr = 16'(4 * int'($urandom_range(0, 255)));
      end
      @(posedge clk);
      if (redirect_valid) load_stream(int'(redirect_addr));
      #1;
      redirect_valid = 1'b0;
      start          = 1'b0;
    end
    out_ready = 1'b1;
    cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
